// File: rtl/vector_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vector_mem_access_ctrl
//  Purpose  : Moves a whole vector between the MEM stage and a single-port,
//             word-addressed data memory. A load issues ELEMS word reads and
//             collects the returned words into one vector. That vector is then
//             presented with its destination register for writeback. A store
//             issues ELEMS word writes from a vector latched when the request
//             is accepted. The pipeline is held off (req_ready low) for the
//             whole access.
//  Ports    : clk, rst                      clock, synchronous active-high reset
//             req_valid/req_is_store        request handshake and op select
//             req_base_addr/req_rd          element-0 word address, load dest
//             req_store_data                store vector (ELEMS x DATA_W)
//             req_stride                    element stride (VMEM_STRIDE_EN only)
//             req_ready                     high only when idle
//             mem_addr/mem_we/mem_wdata     memory request port
//             mem_rdata                     read data, one cycle after address
//             wb_valid/wb_rd/wb_data        completed-load writeback
//             done                          one-cycle completion pulse
//  Config   : VMEM_STRIDE_EN - adds req_stride. Without it the stride is 1.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_mem_access_ctrl #(
    parameter int ELEMS  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_is_store,
    input  logic [ADDR_W-1:0]       req_base_addr,
    input  logic [RD_W-1:0]         req_rd,
    input  logic [ELEMS*DATA_W-1:0] req_store_data,
`ifdef VMEM_STRIDE_EN
    input  logic [ADDR_W-1:0]       req_stride,
`endif
    output logic                    req_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    wb_valid,
    output logic [RD_W-1:0]         wb_rd,
    output logic [ELEMS*DATA_W-1:0] wb_data,
    output logic                    done
);

    localparam int CNT_W = $clog2(ELEMS);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_WB    = 3'd3;
    localparam logic [2:0] c_STORE = 3'd4;
    localparam logic [2:0] c_FIN   = 3'd5;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(ELEMS - 1);

    logic [2:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic [RD_W-1:0]         r_rd;
    logic [DATA_W-1:0]       r_svec [ELEMS];
    logic [DATA_W-1:0]       r_buf  [ELEMS];
    logic                    r_pend;
    logic [CNT_W-1:0]        r_pidx;
    logic [RD_W-1:0]         r_wb_rd;
    logic [ELEMS*DATA_W-1:0] r_wb_data;

    logic [ADDR_W-1:0]       w_stride;
    logic [CNT_W-1:0]        w_sidx;
    logic [CNT_W-1:0]        w_cidx;
    logic                    w_active;
    logic                    w_last;

`ifdef VMEM_STRIDE_EN
    logic [ADDR_W-1:0]       r_stride;
    assign w_stride = r_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    // Element i goes to / comes from vector slot ELEMS-1-i. With a power-of-two
    // ELEMS that slot index is simply the bitwise complement of i.
    assign w_sidx   = ~r_cnt;
    assign w_cidx   = ~r_pidx;
    assign w_active = (r_state == c_LOAD) || (r_state == c_STORE);
    assign w_last   = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_rd      <= '0;
            r_pend    <= 1'b0;
            r_pidx    <= '0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
`ifdef VMEM_STRIDE_EN
            r_stride  <= '0;
`endif
            for (int k = 0; k < ELEMS; k++) begin
                r_svec[k] <= '0;
                r_buf[k]  <= '0;
            end
        end else begin
            // A read issued in a LOAD cycle returns one cycle later. Remember
            // which element it was so it is captured on the following edge.
            r_pend <= (r_state == c_LOAD);
            r_pidx <= r_cnt;
            if (r_pend) begin
                r_buf[w_cidx] <= mem_rdata;
            end

            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_cnt  <= '0;
                        r_addr <= req_base_addr;
                        r_rd   <= req_rd;
`ifdef VMEM_STRIDE_EN
                        r_stride <= req_stride;
`endif
                        for (int k = 0; k < ELEMS; k++) begin
                            r_svec[k] <= req_store_data[k*DATA_W +: DATA_W];
                        end
                        r_state <= req_is_store ? c_STORE : c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_addr <= r_addr + w_stride;
                    if (w_last) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // The final element (slot 0) arrives now. It is merged
                    // straight into the writeback copy, so wb_data only ever
                    // changes to a complete vector.
                    for (int k = 1; k < ELEMS; k++) begin
                        r_wb_data[k*DATA_W +: DATA_W] <= r_buf[k];
                    end
                    r_wb_data[DATA_W-1:0] <= mem_rdata;
                    r_wb_rd <= r_rd;
                    r_state <= c_WB;
                end
                c_WB: begin
                    r_state <= c_IDLE;
                end
                c_STORE: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_addr <= r_addr + w_stride;
                    if (w_last) begin
                        r_state <= c_FIN;
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == c_IDLE);
    assign mem_addr  = w_active ? r_addr : '0;
    assign mem_we    = (r_state == c_STORE);
    assign mem_wdata = (r_state == c_STORE) ? r_svec[w_sidx] : '0;
    assign wb_valid  = (r_state == c_WB);
    assign done      = (r_state == c_WB) || (r_state == c_FIN);
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_mem_access_ctrl
//  Purpose  : Self-checking bench for vector_mem_access_ctrl. A registered RAM
//             model is attached to the memory port. A reference memory image
//             predicts every cycle of each op and the final memory contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vector_mem_access_ctrl;

    localparam int ELEMS = 16;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int RW    = 5;
    localparam int VW    = ELEMS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_is_store;
    logic [AW-1:0] req_base_addr;
    logic [RW-1:0] req_rd;
    logic [VW-1:0] req_store_data;
    logic [AW-1:0] req_stride;
    logic          req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [VW-1:0] wb_data;
    logic          done;

    always #5 clk = ~clk;

    vector_mem_access_ctrl #(.ELEMS(ELEMS), .DATA_W(DW), .ADDR_W(AW), .RD_W(RW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_is_store   (req_is_store),
        .req_base_addr  (req_base_addr),
        .req_rd         (req_rd),
        .req_store_data (req_store_data),
`ifdef VMEM_STRIDE_EN
        .req_stride     (req_stride),
`endif
        .req_ready      (req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .done           (done)
    );

    // Registered RAM. An address that has never been written reads a ^ 0xA5A5.
    bit [DW-1:0] ram    [65536];
    bit          ram_wr [65536];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : (mem_addr ^ 16'hA5A5);
    end

    // Reference image and expected writeback state
    bit [DW-1:0]   ref_mem [65536];
    bit            ref_wr  [65536];
    logic [VW-1:0] exp_wb_data = '0;
    logic [RW-1:0] exp_wb_rd   = '0;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : (a ^ 16'hA5A5);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Waits for an idle cycle, then presents the request. Returns at the
    // negedge of cycle 1 (the first cycle after the accepting edge), with
    // req_valid still high.
    task automatic issue(input bit st, input logic [AW-1:0] base, input logic [RW-1:0] rd,
                         input logic [VW-1:0] vec, input logic [AW-1:0] stride);
        int w;
        w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: actual %b required 1", req_ready);
        end
        req_valid      = 1'b1;
        req_is_store   = st;
        req_base_addr  = base;
        req_rd         = rd;
        req_store_data = vec;
        req_stride     = stride;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks each cycle of an accepted op, starting at the negedge of cycle 1.
    // Ends at the negedge of the first idle cycle after completion.
    task automatic monitor_op(input bit st, input logic [AW-1:0] base, input logic [RW-1:0] rd,
                              input logic [VW-1:0] vec, input logic [AW-1:0] stride,
                              output int done_cyc, output logic [AW-1:0] last_addr);
        logic [VW-1:0] ld_vec;
        logic [AW-1:0] a_e;
        logic [DW-1:0] d_e;
        bit            act;
        int            ncyc;
        ld_vec = '0;
        for (int k = 0; k < ELEMS; k++) begin
            ld_vec[(ELEMS-1-k)*DW +: DW] = ref_rd(AW'(base + k * stride));
        end
        ncyc      = st ? ELEMS + 1 : ELEMS + 2;
        done_cyc  = -1;
        last_addr = '0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) @(negedge clk);
            act = (c <= ELEMS);
            a_e = act ? AW'(base + (c - 1) * stride) : '0;
            d_e = (st && act) ? vec[(ELEMS-c)*DW +: DW] : '0;
            if (!st && c == ncyc) begin
                exp_wb_data = ld_vec;
                exp_wb_rd   = rd;
            end
            chk($sformatf("%s_c%0d_outputs", st ? "store" : "load", c),
                {req_ready, mem_we, wb_valid, done, mem_addr, mem_wdata},
                {1'b0, st && act, !st && c == ncyc, c == ncyc, a_e, d_e});
            chk($sformatf("c%0d_wb_rd", c), wb_rd, exp_wb_rd);
            chkw($sformatf("c%0d_wb_data", c), wb_data, exp_wb_data);
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == ELEMS) last_addr = mem_addr;
        end
        if (st) begin
            for (int k = 0; k < ELEMS; k++) begin
                ref_mem[AW'(base + k * stride)] = vec[(ELEMS-1-k)*DW +: DW];
                ref_wr[AW'(base + k * stride)]  = 1'b1;
            end
        end
        @(negedge clk);
        chk("idle_after_op", {req_ready, mem_we, wb_valid, done, mem_addr, mem_wdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
    endtask

    task automatic do_op(input bit st, input logic [AW-1:0] base, input logic [RW-1:0] rd,
                         input logic [VW-1:0] vec, input logic [AW-1:0] stride,
                         output int done_cyc, output logic [AW-1:0] last_addr);
        issue(st, base, rd, vec, stride);
        // Inputs change while busy; the block must ignore them
        req_valid      = 1'b0;
        req_is_store   = ~st;
        req_base_addr  = AW'($urandom);
        req_rd         = RW'($urandom);
        req_store_data = {8{32'($urandom)}};
        do_op_mon: monitor_op(st, base, rd, vec, stride, done_cyc, last_addr);
    endtask

    function automatic logic [VW-1:0] ramp_vec(input logic [DW-1:0] pat);
        logic [VW-1:0] v;
        for (int k = 0; k < ELEMS; k++) v[k*DW +: DW] = pat + DW'(k);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < ELEMS; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    typedef struct {
        bit            st;
        logic [AW-1:0] base;
        logic [RW-1:0] rd;
        logic [DW-1:0] pat;
        int            exp_done;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            dc;
        logic [AW-1:0] la;
        logic [VW-1:0] v;
        logic [AW-1:0] b;
        logic [AW-1:0] s;
        int            bad;

        tbl[0] = '{1'b0, 16'h0010, 5'd5,  16'h0000, 18, 16'h001F};
        tbl[1] = '{1'b1, 16'h0100, 5'd0,  16'h1000, 17, 16'h010F};
        tbl[2] = '{1'b0, 16'hFFFC, 5'd3,  16'h0000, 18, 16'h000B};
        tbl[3] = '{1'b0, 16'h0100, 5'd9,  16'h0000, 18, 16'h010F};
        tbl[4] = '{1'b1, 16'hFFF8, 5'd0,  16'hBEE0, 17, 16'h0007};

        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_base_addr = '0;
        req_rd = '0; req_store_data = '0; req_stride = 16'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {req_ready, mem_we, wb_valid, done, mem_addr, mem_wdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
        chk("reset_wb_rd", wb_rd, 0);
        chkw("reset_wb_data", wb_data, '0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].st, tbl[i].base, tbl[i].rd, ramp_vec(tbl[i].pat), 16'd1, dc, la);
            chk($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].exp_done);
            chk($sformatf("tbl%0d_last_addr", i), la, tbl[i].exp_last);
            if (i == 0) begin
                chk("tbl0_wb15", wb_data[255:240], 16'hA5B5);
                chk("tbl0_wb0", wb_data[15:0], 16'hA5BA);
                chk("tbl0_rd", wb_rd, 5);
            end
            if (i == 3) begin
                chk("tbl3_wb15", wb_data[255:240], 16'h100F);
                chk("tbl3_wb0", wb_data[15:0], 16'h1000);
            end
        end

        // Reset in cycle 8 of a load aborts it
        issue(1'b0, 16'h0040, 5'd7, '0, 16'd1);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_c8_addr", mem_addr, 16'h0047);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_wb_data = '0;
        exp_wb_rd   = '0;
        chk("abort_outputs", {req_ready, mem_we, wb_valid, done, mem_addr, mem_wdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
        chk("abort_wb_rd", wb_rd, 0);
        chkw("abort_wb_data", wb_data, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_pulse", {wb_valid, done}, 2'b00);
        end
        do_op(1'b0, 16'h0040, 5'd7, '0, 16'd1, dc, la);
        chk("after_abort_done_cycle", dc, 18);

        // Load then store with req_valid held high throughout
        v = rand_vec();
        issue(1'b0, 16'h0020, 5'd11, '0, 16'd1);
        req_is_store   = 1'b1;
        req_base_addr  = 16'h0200;
        req_store_data = v;
        monitor_op(1'b0, 16'h0020, 5'd11, '0, 16'd1, dc, la);
        chk("b2b_load_done", dc, 18);
        @(negedge clk);
        req_valid = 1'b0;
        monitor_op(1'b1, 16'h0200, 5'd0, v, 16'd1, dc, la);
        chk("b2b_store_done", dc, 17);

`ifdef VMEM_STRIDE_EN
        do_op(1'b0, 16'h0000, 5'd2, '0, 16'd4, dc, la);
        chk("stride4_last", la, 16'h003C);
        do_op(1'b0, 16'h0033, 5'd4, '0, 16'd0, dc, la);
        for (int k = 0; k < ELEMS; k++) begin
            chk($sformatf("stride0_elem%0d", k), wb_data[k*DW +: DW], ref_rd(16'h0033));
        end
`endif

        // Randomized ops against the reference image
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) b = 16'hFFF0 + AW'($urandom_range(0, 15));
            else b = AW'($urandom_range(0, 96));
`ifdef VMEM_STRIDE_EN
            s = AW'($urandom_range(0, 5));
`else
            s = 16'd1;
`endif
            do_op(1'($urandom), b, RW'($urandom), rand_vec(), s, dc, la);
        end

        bad = 0;
        for (int a = 0; a < 65536; a++) begin
            if (ram_wr[a] != ref_wr[a] || (ref_wr[a] && ram[a] != ref_mem[a])) bad++;
        end
        chk("memory_image_mismatches", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
